fetch_unit: RTL

Instruction fetch controller for the 16-bit processor. Owns the program counter that addresses the combinational instruction memory, and buffers fetched instructions in a small prefetch queue. Hands them to decode via a valid/ready handshake. Supports branch/jump redirect with queue flush and a sticky halt. Sits between the instruction memory and the decode/issue stage.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/fetch_queue.sv | 69 ++++++
 rtl/fetch_unit.sv | 81 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared widths, constants and fetch state encoding for the 16-bit processor front end.
// Also provides the PC alignment helper used on redirect.
package cpu_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;

  localparam logic [PC_W-1:0]    PC_STEP   = 16'd2;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic {
    FETCH_RUN,
    FETCH_HALT
  } fetch_state_t;

  // Instructions live at even byte addresses; bit 0 of a target is ignored.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, instr} pairs between instruction memory and decode.
// Circular buffer with a flush that empties it and takes priority over push.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic               i_flush,
  input  logic [PC_W-1:0]    i_push_pc,
  input  logic [INSTR_W-1:0] i_push_instr,
  output logic               o_full,
  output logic               o_empty,
  output logic [PC_W-1:0]    o_head_pc,
  output logic [INSTR_W-1:0] o_head_instr
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PC_W-1:0]    r_pc    [DEPTH];
  logic [INSTR_W-1:0] r_instr [DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]    <= '0;
        r_instr[i] <= NOP_INSTR;
      end
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_pc[r_wr_ptr]    <= i_push_pc;
        r_instr[r_wr_ptr] <= i_push_instr;
        r_wr_ptr          <= ptr_inc(r_wr_ptr);
      end
      if (i_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_empty      = (r_count == '0);
  assign o_full       = (r_count == CNT_W'(DEPTH));
  assign o_head_pc    = r_pc[r_rd_ptr];
  assign o_head_instr = r_instr[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch controller: owns fetch_pc, feeds the prefetch queue and
// handles redirect flushes and the sticky halt.
//
//   state      | meaning
//   FETCH_RUN  | fetch one instruction per cycle when the queue has room
//   FETCH_HALT | fetch_pc frozen, no fetch; queue still drains to decode
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
  parameter int              DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_pc,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt_req,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic               halted
);

  fetch_state_t    r_state;
  logic [PC_W-1:0] r_fetch_pc;
  logic            r_halted;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_pop  = !w_empty && out_ready;
  // A full queue still accepts a fetch when decode frees the head this cycle.
  assign w_push = (r_state == FETCH_RUN) && !redirect_valid && !halt_req
                  && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= FETCH_RUN;
      r_fetch_pc <= RESET_PC;
      r_halted   <= 1'b0;
    end else if (redirect_valid) begin
      r_state    <= FETCH_RUN;
      r_fetch_pc <= align_pc(redirect_pc);
      r_halted   <= 1'b0;
    end else begin
      if (w_push) begin
        r_fetch_pc <= r_fetch_pc + PC_STEP;
      end
      if (halt_req) begin
        r_state  <= FETCH_HALT;
        r_halted <= 1'b1;
      end
    end
  end

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_flush     (redirect_valid),
    .i_push_pc   (r_fetch_pc),
    .i_push_instr(imem_instr),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head_pc   (out_pc),
    .o_head_instr(out_instr)
  );

  assign imem_pc   = r_fetch_pc;
  assign out_valid = !w_empty;
  assign halted    = r_halted;

endmodule
